// File: rtl/lfsr_stream_checker_if.sv
// Stream/status bundle between an LFSR pattern source (master) and
// lfsr_stream_checker (slave).
interface lfsr_stream_checker_if #(
  parameter int unsigned ERR_W = 16
);
  logic             in_valid;
  logic             in_bit;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      sr_out;

  modport master (
    output in_valid, in_bit, clear_err,
    input  locked, err_pulse, err_count, sr_out
  );

  modport slave (
    input  in_valid, in_bit, clear_err,
    output locked, err_pulse, err_count, sr_out
  );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 16-bit Fibonacci LFSR stream (taps 16,14,13,11):
// self-synchronises, declares lock, then counts bit errors with saturation.
module lfsr_stream_checker #(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned LOSS_COUNT = 8,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  lfsr_stream_checker_if.slave bus
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [15:0]        sr_q, sr_d;
  logic [4:0]         fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic               pred;
  logic               err_hit;

  assign pred = sr_q[15] ^ sr_q[13] ^ sr_q[12] ^ sr_q[10];

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    err_hit     = 1'b0;

    if (bus.in_valid) begin
      case (state_q)
        SEARCH: begin
          sr_d = {sr_q[14:0], bus.in_bit};
          // fill_q[4] set means 16 bits are loaded and prediction is meaningful
          if (!fill_q[4]) begin
            fill_d = fill_q + 5'd1;
          end else if ((bus.in_bit == pred) && (sr_q != '0)) begin
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Free-running local sequence: a single flipped input bit costs one error only
          sr_d = {sr_q[14:0], pred};
          if (bus.in_bit != pred) begin
            err_hit     = 1'b1;
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (miss_q == MISS_LAST) begin
              state_d = SEARCH;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (bus.clear_err) begin
      err_count_d = err_hit ? ERR_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.sr_out    = sr_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Randomised bench for lfsr_stream_checker: two instances (ERR_W=16 and ERR_W=4)
// share one stimulus and are compared against a bit-history reference model.
module tb_lfsr_stream_checker;

  localparam int LOCK_COUNT = 32;
  localparam int LOSS_COUNT = 8;

  logic clk;
  logic nReset;

  lfsr_stream_checker_if #(.ERR_W(16)) bif16 ();
  lfsr_stream_checker_if #(.ERR_W(4))  bif4 ();

  lfsr_stream_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(16)) u_dut16 (
    .clk(clk), .nReset(nReset), .bus(bif16)
  );
  lfsr_stream_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .ERR_W(4)) u_dut4 (
    .clk(clk), .nReset(nReset), .bus(bif4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: history of the last 16 local-sequence bits, oldest first
  bit  hist[$];
  bit  m_locked, m_pulse;
  int  m_fill, m_match, m_miss, m_err16, m_err4;

  logic [15:0] g;
  int  vcnt, lock_at, pulse_cnt;
  bit  prev_locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit gen_next();
    bit b;
    b = g[15] ^ g[13] ^ g[12] ^ g[10];
    g = {g[14:0], b};
    return b;
  endfunction

  function automatic void model_reset();
    hist = {};
    repeat (16) hist.push_back(1'b0);
    m_locked = 0; m_pulse = 0;
    m_fill = 0; m_match = 0; m_miss = 0; m_err16 = 0; m_err4 = 0;
  endfunction

  function automatic void model_step(bit v, bit b, bit c);
    bit p, nz, hit;
    hit = 0;
    m_pulse = 0;
    if (v) begin
      // hist[k] is the bit received 16-k bits ago: taps 16,14,13,11
      p = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
      nz = 0;
      foreach (hist[i]) nz |= hist[i];
      if (!m_locked) begin
        if (m_fill < 16) m_fill++;
        else if (b == p && nz) begin
          m_match++;
          if (m_match == LOCK_COUNT) begin m_locked = 1; m_miss = 0; end
        end else m_match = 0;
        hist.push_back(b);
      end else begin
        hist.push_back(p);
        if (b != p) begin
          hit = 1; m_pulse = 1;
          if (m_err16 < 65535) m_err16++;
          if (m_err4 < 15) m_err4++;
          m_miss++;
          if (m_miss == LOSS_COUNT) begin m_locked = 0; m_fill = 0; m_match = 0; end
        end else m_miss = 0;
      end
      void'(hist.pop_front());
    end
    if (c) begin
      m_err16 = hit ? 1 : 0;
      m_err4  = hit ? 1 : 0;
    end
  endfunction

  task automatic compare_all();
    logic [15:0] e;
    for (int i = 0; i < 16; i++) e[i] = hist[15 - i];
    check("locked",     bif16.locked,    m_locked);
    check("err_pulse",  bif16.err_pulse, m_pulse);
    check("err_count",  bif16.err_count, m_err16);
    check("sr_out",     bif16.sr_out,    e);
    check("err_count4", bif4.err_count,  m_err4);
    check("locked4",    bif4.locked,     m_locked);
  endtask

  task automatic drive(input bit v, input bit b, input bit c);
    bif16.in_valid = v; bif16.in_bit = b; bif16.clear_err = c;
    bif4.in_valid  = v; bif4.in_bit  = b; bif4.clear_err  = c;
  endtask

  task automatic cycle(input bit v, input bit b, input bit c);
    drive(v, b, c);
    @(posedge clk);
    model_step(v, b, c);
    if (v) vcnt++;
    @(negedge clk);
    compare_all();
    if (bif16.locked && !prev_locked) lock_at = vcnt;
    prev_locked = bif16.locked;
    if (bif16.err_pulse) pulse_cnt++;
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    nReset = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    nReset = 1'b1;
    compare_all();
    vcnt = 0; lock_at = -1; prev_locked = 0; pulse_cnt = 0;
  endtask

  int n, nv;

  initial begin
    nReset = 1'b0;
    drive(0, 0, 0);
    model_reset();
    @(negedge clk);

    // 1: clean contiguous stream from seed ACE1
    do_reset();
    check("rst_locked", bif16.locked, 0);
    check("rst_err", bif16.err_count, 0);
    g = 16'hACE1;
    repeat (1000) cycle(1, gen_next(), 0);
    check("s1_lock_at", lock_at, 48);
    check("s1_err", bif16.err_count, 0);

    // 2: all-zero stream must never lock
    do_reset();
    repeat (200) cycle(1, 0, 0);
    check("s2_locked", bif16.locked, 0);
    check("s2_sr", bif16.sr_out, 0);
    check("s2_err", bif16.err_count, 0);

    // 3: single flipped bit while locked
    do_reset();
    g = 16'hACE1;
    repeat (60) cycle(1, gen_next(), 0);
    pulse_cnt = 0;
    cycle(1, !gen_next(), 0);
    check("s3_pulse", bif16.err_pulse, 1);
    repeat (500) cycle(1, gen_next(), 0);
    check("s3_pulses", pulse_cnt, 1);
    check("s3_err", bif16.err_count, 1);
    check("s3_locked", bif16.locked, 1);

    // 4: eight consecutive flipped bits drop lock, then relock
    cycle(1, gen_next(), 1);
    check("s4_clr", bif16.err_count, 0);
    repeat (7) cycle(1, !gen_next(), 0);
    check("s4_locked7", bif16.locked, 1);
    cycle(1, !gen_next(), 0);
    check("s4_locked8", bif16.locked, 0);
    check("s4_err", bif16.err_count, 8);
    n = 0;
    while (!bif16.locked && n < 100) begin
      cycle(1, gen_next(), 0);
      n++;
    end
    check("s4_relock", n, 48);

    // 5: ~30% idle gaps, same lock point in valid bits
    do_reset();
    g = 16'hACE1;
    nv = 0;
    while (nv < 1000) begin
      if ($urandom_range(99) < 30) cycle(0, 1'($urandom), 0);
      else begin cycle(1, gen_next(), 0); nv++; end
    end
    check("s5_lock_at", lock_at, 48);
    check("s5_err", bif16.err_count, 0);

    // Random gaps, flips and clears against the model
    do_reset();
    g = 16'($urandom_range(65535, 1));
    repeat (4000) begin
      bit v, b, c;
      v = ($urandom_range(99) >= 30);
      b = gen_next();
      if (!v) g = {1'b0, g[15:1]} | {g[0], 15'd0};
      if ($urandom_range(99) < 3) b = !b;
      c = ($urandom_range(99) < 2);
      cycle(v, b, c);
    end

    // 6: clear coinciding with an error, ERR_W=4 saturation, reset mid-lock
    do_reset();
    g = 16'hACE1;
    repeat (60) cycle(1, gen_next(), 0);
    cycle(1, !gen_next(), 1);
    check("s6_clr_hit", bif16.err_count, 1);
    check("s6_clr_hit4", bif4.err_count, 1);
    repeat (20) begin
      cycle(1, !gen_next(), 0);
      repeat (20) cycle(1, gen_next(), 0);
    end
    check("s6_sat4", bif4.err_count, 15);
    check("s6_err16", bif16.err_count, 21);
    check("s6_locked", bif16.locked, 1);
    do_reset();
    check("s6_rst_locked", bif16.locked, 0);
    check("s6_rst_err", bif16.err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
